// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader
//   Instruction memory for the fetch stage. The program is streamed in at run
//   time as bytes, most-significant byte of each word first. The bytes are
//   assembled into words and written from address 0 upward. Fetch is enabled
//   once the requested number of words has been written.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   load_start   one-cycle pulse: begin a load session, latch load_count
//   load_count   number of words in the session (clamped to DEPTH)
//   load_valid   load_byte is valid this cycle
//   load_byte    program byte
//   load_ready   high in LOAD; a byte is taken when load_valid && load_ready
//   address      fetch address
//   iRAMOutput   registered fetch data (NOP_WORD when nothing valid)
//   fetch_valid  iRAMOutput is valid for the address of the previous cycle
//   mem_ready    high in RUN
//   words_loaded words written in the current/last session
module instruction_memory_loader #(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         ADDR_WIDTH = 10,
    parameter int unsigned         DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h6C000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] iRAMOutput,
    output logic                  fetch_valid,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BC_W-1:0]     LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   count_latched;
    logic [ADDR_WIDTH:0]   start_count;
    logic [BC_W-1:0]       byte_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  byte_take;
    logic                  word_done;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign load_ready = (state == LOAD);
    assign mem_ready  = (state == RUN);

    assign start_count = (load_count > DEPTH_W) ? DEPTH_W : load_count;
    assign shift_next  = (shift << 8) | DATA_WIDTH'(load_byte);

    // load_start takes priority over a byte presented on the same edge.
    assign byte_take = reset && !load_start && (state == LOAD) && load_valid;
    assign word_done = byte_take && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            count_latched <= '0;
            words_loaded  <= '0;
            byte_cnt      <= '0;
            shift         <= '0;
        end else if (load_start) begin
            count_latched <= start_count;
            words_loaded  <= '0;
            byte_cnt      <= '0;
            shift         <= '0;
            state         <= (start_count == '0) ? RUN : LOAD;
        end else if (byte_take) begin
            if (word_done) begin
                byte_cnt     <= '0;
                shift        <= '0;
                words_loaded <= words_loaded + 1'b1;
                if (words_loaded + 1'b1 == count_latched)
                    state <= RUN;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
                shift    <= shift_next;
            end
        end
    end

    // words_loaded < count_latched <= DEPTH whenever a word completes,
    // so the low ADDR_WIDTH bits always form an in-range index.
    always_ff @(posedge clock) begin
        if (word_done)
            mem[words_loaded[ADDR_WIDTH-1:0]] <= shift_next;
    end

    // Since words_loaded <= DEPTH, address < words_loaded also covers the
    // address >= DEPTH case.
    always_ff @(posedge clock) begin
        if (!reset) begin
            iRAMOutput  <= NOP_WORD;
            fetch_valid <= 1'b0;
        end else if (state == RUN) begin
            fetch_valid <= 1'b1;
            if ({1'b0, address} < words_loaded)
                iRAMOutput <= mem[address];
            else
                iRAMOutput <= NOP_WORD;
        end else begin
            iRAMOutput  <= NOP_WORD;
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// tb_instruction_memory_loader
//   Directed bench for instruction_memory_loader with default parameters.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_instruction_memory_loader;

    localparam logic [31:0] NOP = 32'h6C000000;

    logic        clock;
    logic        reset;
    logic        load_start;
    logic [10:0] load_count;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic [9:0]  address;
    logic [31:0] iRAMOutput;
    logic        fetch_valid;
    logic        mem_ready;
    logic [10:0] words_loaded;

    int checks;
    int failures;

    instruction_memory_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .DEPTH(1024),
        .NOP_WORD(32'h6C000000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .load_start(load_start),
        .load_count(load_count),
        .load_valid(load_valid),
        .load_byte(load_byte),
        .load_ready(load_ready),
        .address(address),
        .iRAMOutput(iRAMOutput),
        .fetch_valid(fetch_valid),
        .mem_ready(mem_ready),
        .words_loaded(words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [10:0] cnt);
        load_start = 1'b1;
        load_count = cnt;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [9:0] a,
                         input logic [31:0] exp_data, input logic exp_valid);
        address = a;
        tick();
        checks++;
        if (iRAMOutput !== exp_data || fetch_valid !== exp_valid) begin
            failures++;
            $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=%b",
                     name, iRAMOutput, fetch_valid, exp_data, exp_valid);
        end
    endtask

    task automatic check_status(input string name, input logic exp_lr,
                                input logic exp_mr, input logic [10:0] exp_wl);
        checks++;
        if (load_ready !== exp_lr || mem_ready !== exp_mr || words_loaded !== exp_wl) begin
            failures++;
            $display("FAIL %s: got load_ready=%b mem_ready=%b words_loaded=%0d, expected %b %b %0d",
                     name, load_ready, mem_ready, words_loaded, exp_lr, exp_mr, exp_wl);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        check_status("reset_status", 1'b0, 1'b0, 11'd0);
        checks++;
        if (iRAMOutput !== NOP || fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_fetch: got data=%h valid=%b, expected %h 0",
                     iRAMOutput, fetch_valid, NOP);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_two_words();
        start(11'd2);
        check_status("load2_in_load", 1'b1, 1'b0, 11'd0);
        send_byte(8'h6C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h54); send_byte(8'h00); send_byte(8'h00);
        check_status("load2_seven_bytes", 1'b1, 1'b0, 11'd1);
        send_byte(8'h50);
        check_status("load2_done", 1'b0, 1'b1, 11'd2);
        // the edge that entered RUN still used LOAD fetch rules
        checks++;
        if (fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL load2_first_edge_valid: got %b, expected 0", fetch_valid);
        end
        fetch("fetch_addr1", 10'd1, 32'h54000050, 1'b1);
        fetch("fetch_addr0", 10'd0, 32'h6C000000, 1'b1);
    endtask

    task automatic test_out_of_range();
        fetch("fetch_addr2_boundary", 10'd2, NOP, 1'b1);
        fetch("fetch_addr5", 10'd5, NOP, 1'b1);
        fetch("fetch_addr1023", 10'd1023, NOP, 1'b1);
        fetch("fetch_addr1_again", 10'd1, 32'h54000050, 1'b1);
    endtask

    task automatic test_restart();
        address = 10'd1;
        start(11'd3);
        // the start edge was still in RUN
        checks++;
        if (fetch_valid !== 1'b1) begin
            failures++;
            $display("FAIL restart_valid_hold: got %b, expected 1", fetch_valid);
        end
        send_byte(8'hAA);
        checks++;
        if (fetch_valid !== 1'b0 || iRAMOutput !== NOP) begin
            failures++;
            $display("FAIL restart_valid_drop: got valid=%b data=%h, expected 0 %h",
                     fetch_valid, iRAMOutput, NOP);
        end
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h11); send_byte(8'h22);
        check_status("restart_partial", 1'b1, 1'b0, 11'd1);
        // simultaneous byte must be dropped in favour of load_start
        load_valid = 1'b1;
        load_byte  = 8'hEE;
        start(11'd1);
        load_valid = 1'b0;
        check_status("restart2_started", 1'b1, 1'b0, 11'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check_status("restart2_done", 1'b0, 1'b1, 11'd1);
        tick();
        fetch("restart_addr0", 10'd0, 32'h01020304, 1'b1);
        // mem[1] still holds an older word but lies beyond words_loaded
        fetch("restart_addr1", 10'd1, NOP, 1'b1);
    endtask

    task automatic test_zero_count();
        start(11'd0);
        check_status("zero_count", 1'b0, 1'b1, 11'd0);
        fetch("zero_addr0", 10'd0, NOP, 1'b1);
        fetch("zero_addr7", 10'd7, NOP, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        start(11'd2);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_status("midreset_status", 1'b0, 1'b0, 11'd0);
        checks++;
        if (fetch_valid !== 1'b0 || iRAMOutput !== NOP) begin
            failures++;
            $display("FAIL midreset_fetch: got valid=%b data=%h, expected 0 %h",
                     fetch_valid, iRAMOutput, NOP);
        end
        send_byte(8'h78); send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
        check_status("idle_bytes_ignored", 1'b0, 1'b0, 11'd0);
        fetch("idle_fetch", 10'd0, NOP, 1'b0);
        // leftover partial word must not leak into the next session
        start(11'd1);
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
        check_status("after_reset_load", 1'b0, 1'b1, 11'd1);
        tick();
        fetch("after_reset_addr0", 10'd0, 32'h0A0B0C0D, 1'b1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        load_start = 1'b0;
        load_count = '0;
        load_valid = 1'b0;
        load_byte  = '0;
        address    = '0;
        #2;
        test_reset();
        test_load_two_words();
        test_out_of_range();
        test_restart();
        test_zero_count();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Parametrised instruction memory for the processor fetch stage, with a runtime byte-stream program loader in place of a program fixed at synthesis.
- An upstream source, such as the UART or bench, streams a word count and then program bytes. The block assembles the bytes into words, writes them sequentially from address 0, and then enables fetch.
- Fetch has a registered read port with a valid flag. Any non-loaded or out-of-range read returns the NOP encoding.

Parameters:
DATA_WIDTH, 32, instruction word width; must be a multiple of 8
ADDR_WIDTH, 10, fetch/write address width
DEPTH, 1024, number of words; must be <= 2**ADDR_WIDTH
NOP_WORD, 32'h6C000000, word returned when no valid instruction is available

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
load_start  input  1  one-cycle pulse that begins a load session and latches load_count
load_count  input  ADDR_WIDTH+1  number of words in the session
load_valid  input  1  load_byte is valid this cycle
load_byte  input  8  program byte, most-significant byte of each word first
load_ready  output  1  high while in LOAD; a byte is accepted when load_valid && load_ready
address  input  ADDR_WIDTH  fetch address
iRAMOutput  output  DATA_WIDTH  registered fetch data
fetch_valid  output  1  iRAMOutput holds a valid instruction for the address presented one cycle earlier
mem_ready  output  1  high in RUN state
words_loaded  output  ADDR_WIDTH+1  number of words written in the current/last session

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; iRAMOutput=NOP_WORD; fetch_valid=0; load_ready=0; mem_ready=0; words_loaded=0.
  - Byte counter and shift register are cleared.
  - Memory contents are not cleared; they are invalid until the next load completes.
- BYTES = DATA_WIDTH/8.
- State machine IDLE / LOAD / RUN:
  - IDLE: load_start -> LOAD.
  - LOAD: each accepted byte shifts into the assembly register and the byte counter increments. On the BYTES-th byte, the full word {shift, load_byte} is written at mem[words_loaded], words_loaded increments, and the byte counter returns to 0. When words_loaded reaches the latched count -> RUN in the same edge as the final write.
  - RUN: stays in RUN until load_start or reset.
- Load start handling:
  - On load_start, count_latched = min(load_count, DEPTH), words_loaded=0, byte counter=0.
  - If count_latched==0, go directly to RUN.
- load_start during LOAD or RUN restarts the session. A partially assembled word is discarded, and previously written words are not erased.
- load_start wins over a simultaneous load_valid byte; that byte is dropped.
- load_valid outside LOAD is ignored.
- Fetch, registered with 1-cycle latency, evaluated every cycle:
  - In RUN with address < words_loaded: iRAMOutput <= mem[address], fetch_valid <= 1.
  - In RUN with address >= words_loaded (including >= DEPTH): iRAMOutput <= NOP_WORD, fetch_valid <= 1. This treats unloaded space as NOPs.
  - In IDLE or LOAD: iRAMOutput <= NOP_WORD, fetch_valid <= 0.
- Transition edges:
  - On the edge entering RUN, the fetch register still applies LOAD rules; the first valid output appears one cycle later.
  - On entering LOAD from RUN, fetch_valid drops on the next edge.
- Write/read collision: there is no same-cycle hazard in the fetch path, because writes happen only in LOAD and reads are valid only in RUN.
- Memory write port: single, synchronous, one word per cycle at most.
- Counters: words_loaded never exceeds count_latched, and it never wraps.

Test Plan:
- Reset with reset=0 for 2 cycles -> iRAMOutput=32'h6C000000, fetch_valid=0, mem_ready=0, load_ready=0, words_loaded=0.
- load_start with load_count=2, then bytes 6C 00 00 00 54 00 00 50 -> mem_ready=1 after the 8th byte. Fetch address 1 -> iRAMOutput=32'h54000050 with fetch_valid=1 the next cycle.
- After the previous load, fetch address 5 and then 1023 -> iRAMOutput=32'h6C000000, fetch_valid=1.
- load_count=3, send 6 bytes, then pulse load_start with load_count=1 and send 01 02 03 04 -> words_loaded=1, mem_ready=1. Fetch address 0 -> 32'h01020304.
- load_start with load_count=0 -> mem_ready=1 on the next cycle, words_loaded=0. Any fetch returns NOP with fetch_valid=1.
- Assert reset=0 mid-LOAD after 3 bytes -> state IDLE, load_ready=0. Bytes with load_valid=1 in IDLE leave words_loaded=0.
